pipelined_addsub: RTL

//  Parametrised, pipelined WIDTH-bit adder/subtractor for the Mips32bit datapath.

---
 rtl/alu_pkg.sv | 8 +
 rtl/adder_segment.sv | 22 ++
 rtl/pipelined_addsub.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the Mips32bit datapath.
//   ALU_WIDTH : native datapath width
//   ADD / SUB : encoding of the add/subtract select line
package alu_pkg;
    localparam int   ALU_WIDTH = 32;
    localparam logic ADD       = 1'b0;
    localparam logic SUB       = 1'b1;
endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit adder slice used by each stage of pipelined_addsub.
// Ports:
//   a_i, b_i   : SEG-bit operand slices (b_i already inverted for subtract)
//   cin_i      : carry into the slice
//   sum_o      : SEG-bit slice sum
//   cout_o     : carry out of the slice MSB
//   msb_cin_o  : carry into the slice MSB (used for signed overflow at the top slice)
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o,
    output logic           msb_cin_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

    // The MSB sum bit is a^b^cin at that position, so the carry into it falls out directly.
    assign msb_cin_o = a_i[SEG-1] ^ b_i[SEG-1] ^ sum_o[SEG-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES equal segments.
// Each stage adds one segment and registers its carry into the next stage; the
// not-yet-added upper operand segments travel alongside as registered skew.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand bundle handshake (a, b, carry_in, sub)
//   out_valid / out_ready: result bundle handshake (sum, carry_out, overflow, zero)
//   sub                  : 0 = a+b+carry_in, 1 = a-b-carry_in (carry_in acts as borrow)
//   carry_out            : add: carry out; sub: 1 = borrow occurred
//   overflow, zero       : signed overflow and sum==0 flags
//
// Handshake: a bundle moves when valid & ready are both high on a rising edge. The
// producer holds its bundle stable while valid is high and ready is low. Here the whole
// pipe shares one enable (en = ~out_valid | out_ready); in_ready equals en, so nothing
// moves anywhere while a result is waiting on a stalled consumer.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = (STAGES > 0) ? WIDTH / STAGES : WIDTH;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_addsub: STAGES must be in 1..WIDTH");
    end else if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
    end

    // Stage registers: index k holds the bundle after segment k has been added.
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             ovf_q;
    logic             cout_q;
    logic             zero_q;

    // Inputs seen by stage k (port values for k = 0, previous register otherwise).
    logic             st_v   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_c   [STAGES];
    logic             st_sub [STAGES];

    logic [SEG-1:0]   seg_s   [STAGES];
    logic             seg_c   [STAGES];
    logic             seg_msb [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];

    logic en;

    assign en       = ~v_q[STAGES-1] | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Subtract is a + ~b + 1 with the borrow folded into the inverted carry-in.
            assign st_v[k]   = in_valid;
            assign st_a[k]   = a;
            assign st_b[k]   = (sub == SUB) ? ~b : b;
            assign st_c[k]   = (sub == SUB) ? ~carry_in : carry_in;
            assign st_sum[k] = '0;
            assign st_sub[k] = sub;
        end else begin : g_body
            assign st_v[k]   = v_q[k-1];
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_c[k]   = c_q[k-1];
            assign st_sum[k] = sum_q[k-1];
            assign st_sub[k] = sub_q[k-1];
        end

        adder_segment #(.SEG(SEG)) u_seg (
            .a_i       (st_a[k][k*SEG +: SEG]),
            .b_i       (st_b[k][k*SEG +: SEG]),
            .cin_i     (st_c[k]),
            .sum_o     (seg_s[k]),
            .cout_o    (seg_c[k]),
            .msb_cin_o (seg_msb[k])
        );

        // Drop this stage's result slice into the accumulating sum, keep the lower slices.
        assign sum_d[k] = (st_sum[k] & ~(SEG_MASK << (k*SEG)))
                        | (WIDTH'(seg_s[k]) << (k*SEG));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            // Bubbles shift with everything else; no compaction.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= st_v[k];
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= seg_c[k];
                sub_q[k] <= st_sub[k];
            end
            // Flags come from the top slice as it is added.
            ovf_q  <= seg_msb[STAGES-1] ^ seg_c[STAGES-1];
            cout_q <= seg_c[STAGES-1] ^ st_sub[STAGES-1];
            zero_q <= ~|sum_d[STAGES-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule
